// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: prescaled PWM brightness, per-digit scan,
// leading-zero suppression and frame-synchronous double-buffered loading.
module seg7_scan #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic                  LOAD,
    input  logic                  LZ_EN,
    input  logic [3:0]            BRIGHT,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN,
    output logic                  PENDING,
    output logic                  FRAME
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]          presc;
    logic [3:0]             phase;
    logic [IW-1:0]          index;
    logic [4*DIGITS-1:0]    pend_val;
    logic [4*DIGITS-1:0]    shadow_val;
    logic [DIGITS-1:0]      pend_dp;
    logic [DIGITS-1:0]      shadow_dp;

    logic                   tick;
    logic                   boundary;
    logic                   lit;
    logic                   blank;
    logic                   acc;
    logic [3:0]             nib;
    logic [6:0]             hex_seg;
    logic [6:0]             seg_d;
    logic                   dp_d;
    logic [DIGITS-1:0]      an_d;
    logic [DIGITS-1:0]      zero_above;

    assign tick     = (presc == P_LAST);
    assign boundary = tick && (phase == 4'd15) && (index == I_LAST);

    // zero_above[i] is set when every shadow digit from the top down to i is zero
    always_comb begin
        zero_above = '0;
        acc        = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            int unsigned i;
            i             = DIGITS - 1 - j;
            acc           = acc & (shadow_val[4*i +: 4] == 4'd0);
            zero_above[i] = acc;
        end
    end

    always_comb begin
        nib = shadow_val[{index, 2'b00} +: 4];
        case (nib)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    always_comb begin
        lit   = (phase <= BRIGHT);
        blank = LZ_EN && (index != '0) && zero_above[index];
        an_d  = lit ? ~(DIGITS'(1) << index) : '1;
        seg_d = (lit && !blank) ? hex_seg : 7'h7F;
        dp_d  = lit ? ~shadow_dp[index] : 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc      <= '0;
            phase      <= '0;
            index      <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            PENDING    <= 1'b0;
            FRAME      <= 1'b0;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            AN         <= '1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                phase <= phase + 1'b1;
                if (phase == 4'd15)
                    index <= (index == I_LAST) ? '0 : index + 1'b1;
            end
            FRAME <= boundary;
            SEG   <= seg_d;
            DP    <= dp_d;
            AN    <= an_d;
            // A load landing exactly on the boundary bypasses the pending buffer
            if (boundary) begin
                if (LOAD) begin
                    shadow_val <= VALUE;
                    shadow_dp  <= DP_IN;
                end else if (PENDING) begin
                    shadow_val <= pend_val;
                    shadow_dp  <= pend_dp;
                end
                PENDING <= 1'b0;
            end else if (LOAD) begin
                pend_val <= VALUE;
                pend_dp  <= DP_IN;
                PENDING  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a cycle-count model pushes expected outputs
// to a queue each cycle; they are popped and checked one cycle later.
module tb_seg7_scan;

    localparam int P  = 2;
    localparam int D  = 4;
    localparam int FR = 16 * P * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame;

    seg7_scan #(.DIGITS(D), .PRESCALE(P)) dut (
        .CLK(clk), .RESET(rst), .VALUE(value), .DP_IN(dp_in), .LOAD(load),
        .LZ_EN(lz_en), .BRIGHT(bright), .SEG(seg), .DP(dp), .AN(an),
        .PENDING(pending), .FRAME(frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       pending;
        logic       frame;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_pend_val = '0;
    logic [3:0]  m_shadow_dp = '0;
    logic [3:0]  m_pend_dp = '0;
    bit          m_pend = 0;
    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s at model cycle %0d: observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    // One clock: model the registered outputs from this cycle's state, then compare
    task automatic step();
        exp_t        e;
        exp_t        got;
        int          ph;
        int          idx;
        bit          bnd;
        bit          on;
        bit          blk;
        logic [15:0] upper;
        ph    = (k / P) % 16;
        idx   = (k / (16 * P)) % D;
        bnd   = (k % FR) == FR - 1;
        on    = ph <= int'(bright);
        upper = m_shadow >> (4 * idx);
        blk   = lz_en && (idx > 0) && (upper == 16'd0);
        e.an    = on ? ~(4'b0001 << idx) : 4'hF;
        e.seg   = (on && !blk) ? tbl[m_shadow[4*idx +: 4]] : 7'h7F;
        e.dp    = on ? ~m_shadow_dp[idx] : 1'b1;
        e.frame = bnd;
        if (bnd) begin
            if (load) begin
                m_shadow    = value;
                m_shadow_dp = dp_in;
            end else if (m_pend) begin
                m_shadow    = m_pend_val;
                m_shadow_dp = m_pend_dp;
            end
            m_pend = 0;
        end else if (load) begin
            m_pend_val = value;
            m_pend_dp  = dp_in;
            m_pend     = 1;
        end
        e.pending = m_pend;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        got = sb.pop_front();
        check("seg", {25'd0, seg}, {25'd0, got.seg});
        check("dp", {31'd0, dp}, {31'd0, got.dp});
        check("an", {28'd0, an}, {28'd0, got.an});
        check("pending", {31'd0, pending}, {31'd0, got.pending});
        check("frame", {31'd0, frame}, {31'd0, got.frame});
        k++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int phase_in_frame);
        while ((k % FR) != phase_in_frame) step();
    endtask

    // Asynchronous assertion mid-cycle, LOAD held high during reset, release on negedge
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_pending", {31'd0, pending}, 32'h0);
        check("rst_frame", {31'd0, frame}, 32'h0);
        value = 16'hFFFF;
        load  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_load_ignored", {31'd0, pending}, 32'h0);
        load = 1'b0;
        rst  = 1'b0;
        k           = 0;
        m_shadow    = '0;
        m_pend_val  = '0;
        m_shadow_dp = '0;
        m_pend_dp   = '0;
        m_pend      = 0;
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        value = 16'h1234;
        load  = 1'b1;
        step();
        run(FR * 2 - 1);

        bright = 4'd3;
        run(FR);
        bright = 4'd15;

        lz_en = 1'b1;
        value = 16'h0050;
        load  = 1'b1;
        step();
        run(FR * 2);
        value = 16'h0000;
        load  = 1'b1;
        step();
        run(FR * 2);

        dp_in = 4'b0100;
        load  = 1'b1;
        step();
        run(FR * 2);
        dp_in = 4'b0000;
        lz_en = 1'b0;

        run_to(40);
        value = 16'hAAAA;
        load  = 1'b1;
        step();
        run(20);
        value = 16'hBBBB;
        load  = 1'b1;
        step();
        run(FR * 2);

        run_to(FR - 1);
        value = 16'h5678;
        load  = 1'b1;
        step();
        run(FR);

        run_to(50);
        value = 16'h9ABC;
        load  = 1'b1;
        step();
        run(5);
        check("pending_before_reset", {31'd0, pending}, 32'h1);
        apply_reset();
        run(FR * 2);

        for (int n = 0; n < 16; n++) begin
            value = 16'(n);
            load  = 1'b1;
            step();
            run(FR * 2 - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
